seq_pattern_tx: RTL and testbench
=================================

// Module: seq_pattern_tx
//
// PURPOSE
//   Serial pattern transmitter; the transmit-side counterpart of the 4-bit
//   Moore sequence detector.
//   - Accepts a PAT_W-bit pattern over a valid/ready handshake.
//   - Shifts the pattern out MSB-first on a single serial wire, one bit per
//     clock.
//   - Repeats the pattern a programmable number of times, with programmable
//     idle gaps between repetitions.
//   - Drives detector stimulus and feeds on-chip loopback self-test through
//     the ui_in[0] serial path.
//
// PARAMETERS
//   PAT_W  default 4  pattern width in bits; legal range 2..16
//   CNT_W  default 4  width of the repeat-count field
//   GAP_W  default 4  width of the idle-gap field, in clock cycles
//
// PORTS
//   clk        in   1      clock
//   rst_n      in   1      reset, asynchronous, active-high
//   pat_data   in   PAT_W  pattern to send; bit PAT_W-1 goes out first
//   rep_cnt    in   CNT_W  number of repetitions; 0 is treated as 1
//   gap        in   GAP_W  idle cycles between repetitions; 0 = back-to-back
//   pat_valid  in   1      request; sampled together with pat_data, rep_cnt, gap
//   pat_ready  out  1      block can accept a request (combinational, state==IDLE)
//   ser_out    out  1      serial data, registered
//   ser_en     out  1      ser_out carries a valid bit this cycle, registered
//   ser_par    out  1      current bit is the parity bit, registered
//   busy       out  1      high from the accept edge until the cycle after done
//   done       out  1      one-cycle pulse; high with the final bit of the final repetition
//
// BEHAVIOUR
//   Clock and reset
//   - Clock clk.
//   - Reset rst_n: asynchronous, active-high.
//   - While reset is asserted, and after it releases:
//     ser_out=0, ser_en=0, ser_par=0, busy=0, done=0, state=IDLE, pat_ready=1.
//
//   Handshake
//   - A request is accepted on a rising edge where pat_valid && pat_ready.
//   - pat_data, rep_cnt and gap are latched on that edge.
//   - Inputs are ignored while pat_ready=0. There is no queueing.
//
//   State machine (encoding in seq_pattern_pkg)
//   - IDLE -> SHIFT on accept. The bit index is loaded with PAT_W-1 and the
//     repetition counter with max(rep_cnt,1).
//   - SHIFT: one bit per cycle. After bit 0:
//     - goes to PAR if the parity feature is compiled in;
//     - otherwise goes to the "end of repetition" decision below.
//   - PAR: one cycle, then the "end of repetition" decision.
//   - End of repetition:
//     - if repetitions remain and gap>0: go to GAP;
//     - if repetitions remain and gap==0: go straight to SHIFT (no dead cycle);
//     - otherwise: go to IDLE.
//   - GAP: lasts exactly gap cycles, then SHIFT.
//
//   Output timing
//   - Outputs are registered. Bit k of the stream (k=0 is the first MSB)
//     appears on ser_out in cycle A+1+k, where A is the accept edge.
//   - ser_en=1 on every data bit and every parity bit. ser_en=0 in IDLE and GAP.
//   - ser_out is forced to 0 whenever ser_en=0.
//   - done rises together with the last ser_en of the last repetition.
//     pat_ready returns the following cycle, so the earliest next accept is
//     one cycle after done.
//   - Total request duration:
//     R*(PAT_W+P) + (R-1)*gap cycles, where R=max(rep_cnt,1) and P=1 with
//     parity, else 0.
//
//   Boundary conditions
//   - rep_cnt at its all-ones maximum is a legal repeat count.
//   - A counter wrap to 0 never terminates a request early.
//   - Reset mid-frame aborts immediately. No partial done is produced and no
//     state survives.
//   - pat_valid held high across done is accepted in the first IDLE cycle.
//
// CONFIGURATION
//   Macro SEQ_PATTERN_TX_PARITY_EN
//   - Defined: after every repetition, one extra bit equal to
//     ^pat_data (even parity) is sent, with ser_en=1 and ser_par=1.
//   - Undefined: the PAR state does not exist, ser_par is tied to 0, and
//     P=0 in the timing formula.
//
// STRUCTURE
//   - seq_pattern_pkg: state enum (IDLE, SHIFT, PAR, GAP), state encoding
//     constants, and the default pattern constant PAT_1011 = 4'b1011.
//   - One sub-module, seq_shift_reg: a loadable PAT_W-bit MSB-first shifter
//     with bit index and last-bit flag.
//   - The FSM, repetition counter and gap counter remain in seq_pattern_tx.
//
// TESTING
//   1. pat_data=4'b1011, rep_cnt=1, gap=0, accept at A
//      -> ser_out 1,0,1,1 in A+1..A+4; ser_en high those 4 cycles;
//         done at A+4; pat_ready at A+5.
//   2. 1011, rep_cnt=3, gap=2
//      -> bits 1011,--,1011,--,1011 (16 cycles); ser_en=0 and ser_out=0 in
//         the gaps; done at A+16.
//   3. rep_cnt=0, and separately rep_cnt=1 with gap=5
//      -> each sends exactly one 1011; no GAP state entered.
//   4. pat_valid pulsed with pat_data=4'hF during busy
//      -> ignored; stream and done unchanged; pat_ready=0 throughout.
//   5. rst_n asserted at bit 2 of repetition 2, then released
//      -> all outputs 0 asynchronously; no done; a new accept is then
//         sent in full.
//   6. Loopback: ser_out drives the 1011 detector input, rep_cnt=2, gap=0
//      -> detector output pulses once per repetition (2 pulses).
//      - With SEQ_PATTERN_TX_PARITY_EN: parity bit=1 and ser_par=1 at A+5.

Source files
------------

// File: rtl/seq_pattern_pkg.sv
// seq_pattern_pkg
//   Shared definitions for the serial pattern transmitter:
//   - FSM state encoding constants and the state_t enum built on them
//   - PAT_1011: the default 4-bit pattern matched by the companion detector
package seq_pattern_pkg;

  localparam logic [1:0] ST_IDLE_ENC  = 2'b00;
  localparam logic [1:0] ST_SHIFT_ENC = 2'b01;
  localparam logic [1:0] ST_PAR_ENC   = 2'b10;
  localparam logic [1:0] ST_GAP_ENC   = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE_ENC,
    SHIFT = ST_SHIFT_ENC,
    PAR   = ST_PAR_ENC,
    GAP   = ST_GAP_ENC
  } state_t;

  localparam logic [3:0] PAT_1011 = 4'b1011;

endpackage

// File: rtl/seq_shift_reg.sv
// seq_shift_reg
//   Loadable MSB-first shifter. The register MSB is the serial output bit,
//   so the bit on o_bit comes straight from a flop. Loading all-zeros is
//   how the parent blanks the line between frames.
//   Ports:
//     clk, rst_n   clock, asynchronous active-high reset
//     i_load       load i_data (takes priority over i_shift)
//     i_shift      shift left by one, zero fill
//     i_data       PAT_W-bit load value
//     o_bit        current MSB
//     o_idx        index of the bit on o_bit (PAT_W-1 down to 0)
//     o_last       o_idx == 0
module seq_shift_reg
  import seq_pattern_pkg::*;
#(
  parameter int PAT_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_load,
  input  logic                     i_shift,
  input  logic [PAT_W-1:0]         i_data,
  output logic                     o_bit,
  output logic [$clog2(PAT_W)-1:0] o_idx,
  output logic                     o_last
);

  localparam int IDX_W = $clog2(PAT_W);

  logic [PAT_W-1:0] r_shift;
  logic [IDX_W-1:0] r_idx;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_shift <= '0;
      r_idx   <= '0;
    end else if (i_load) begin
      r_shift <= i_data;
      r_idx   <= IDX_W'(PAT_W - 1);
    end else if (i_shift) begin
      r_shift <= {r_shift[PAT_W-2:0], 1'b0};
      r_idx   <= r_idx - IDX_W'(1);
    end
  end

  assign o_bit  = r_shift[PAT_W-1];
  assign o_idx  = r_idx;
  assign o_last = (r_idx == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx
//   Serial pattern transmitter. Accepts a pattern over valid/ready, shifts
//   it out MSB-first, repeats it max(rep_cnt,1) times with gap idle cycles
//   between repetitions.
//   Build option: define SEQ_PATTERN_TX_PARITY_EN to append an even-parity
//   bit (ser_par=1) after every repetition; otherwise ser_par is tied 0.
//   Ports:
//     clk, rst_n   clock, asynchronous active-high reset
//     pat_data     pattern, MSB sent first
//     rep_cnt      repetitions (0 behaves as 1)
//     gap          idle cycles between repetitions
//     pat_valid    request strobe; pat_ready: accepting (state IDLE)
//     ser_out      serial data (0 whenever ser_en=0)
//     ser_en       ser_out carries a bit
//     ser_par      current bit is the parity bit
//     busy         request in progress
//     done         pulse with the final bit of the final repetition
//
//   All outputs are registered from next-state decisions, so the bit chosen
//   on an edge is visible in the cycle that follows it. The FSM state always
//   names what is currently on the line: done is visible while the state is
//   still non-IDLE and pat_ready returns one cycle later.
module seq_pattern_tx
  import seq_pattern_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PAT_W-1:0] pat_data,
  input  logic [CNT_W-1:0] rep_cnt,
  input  logic [GAP_W-1:0] gap,
  input  logic             pat_valid,
  output logic             pat_ready,
  output logic             ser_out,
  output logic             ser_en,
  output logic             ser_par,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = $clog2(PAT_W);

`ifdef SEQ_PATTERN_TX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  state_t           r_state,    w_state_next;
  logic [CNT_W-1:0] r_rep_left, w_rep_left_next;
  logic [GAP_W-1:0] r_gap,      w_gap_next;
  logic [GAP_W-1:0] r_gap_cnt,  w_gap_cnt_next;
  logic [PAT_W-1:0] r_pat,      w_pat_next;
  logic             r_ser_en,   w_ser_en_next;
  logic             r_done,     w_done_next;
  logic             r_busy;
`ifdef SEQ_PATTERN_TX_PARITY_EN
  logic             r_ser_par,  w_ser_par_next;
`endif

  logic             w_sh_load;
  logic             w_sh_shift;
  logic [PAT_W-1:0] w_sh_data;
  logic             w_sh_bit;
  logic [IDX_W-1:0] w_sh_idx;
  logic             w_sh_last;
  logic             w_eor;       // end of a repetition reached this cycle
  logic             w_last_rep;

  seq_shift_reg #(.PAT_W(PAT_W)) u_shift (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_sh_load),
    .i_shift (w_sh_shift),
    .i_data  (w_sh_data),
    .o_bit   (w_sh_bit),
    .o_idx   (w_sh_idx),
    .o_last  (w_sh_last)
  );

  // Remaining-repetition counter counts down to 1 and stops there, so an
  // all-ones rep_cnt runs in full and no wrap can end a request early.
  assign w_last_rep = (r_rep_left == CNT_W'(1));

  always_comb begin
    w_state_next    = r_state;
    w_rep_left_next = r_rep_left;
    w_gap_next      = r_gap;
    w_gap_cnt_next  = r_gap_cnt;
    w_pat_next      = r_pat;
    w_ser_en_next   = 1'b0;
    w_done_next     = 1'b0;
`ifdef SEQ_PATTERN_TX_PARITY_EN
    w_ser_par_next  = 1'b0;
`endif
    w_sh_load       = 1'b0;
    w_sh_shift      = 1'b0;
    w_sh_data       = '0;
    w_eor           = 1'b0;

    case (r_state)
      IDLE: begin
        if (pat_valid) begin
          w_state_next    = SHIFT;
          w_pat_next      = pat_data;
          w_gap_next      = gap;
          w_rep_left_next = (rep_cnt == '0) ? CNT_W'(1) : rep_cnt;
          w_sh_load       = 1'b1;
          w_sh_data       = pat_data;
          w_ser_en_next   = 1'b1;
        end
      end

      SHIFT: begin
        if (!w_sh_last) begin
          w_sh_shift    = 1'b1;
          w_ser_en_next = 1'b1;
          // Next visible bit is bit 0 of the final repetition.
          w_done_next   = !PARITY_EN && w_last_rep && (w_sh_idx == IDX_W'(1));
        end else begin
`ifdef SEQ_PATTERN_TX_PARITY_EN
          w_state_next   = PAR;
          w_sh_load      = 1'b1;
          w_sh_data      = {^r_pat, {(PAT_W-1){1'b0}}};
          w_ser_en_next  = 1'b1;
          w_ser_par_next = 1'b1;
          w_done_next    = w_last_rep;
`else
          w_eor = 1'b1;
`endif
        end
      end

`ifdef SEQ_PATTERN_TX_PARITY_EN
      PAR: begin
        w_eor = 1'b1;
      end
`endif

      GAP: begin
        if (r_gap_cnt == '0) begin
          w_state_next  = SHIFT;
          w_sh_load     = 1'b1;
          w_sh_data     = r_pat;
          w_ser_en_next = 1'b1;
        end else begin
          w_gap_cnt_next = r_gap_cnt - GAP_W'(1);
        end
      end

      default: begin
        w_state_next = IDLE;
        w_sh_load    = 1'b1;
      end
    endcase

    // End-of-repetition decision shared by SHIFT (no parity) and PAR.
    // Loading zeros blanks ser_out for GAP/IDLE.
    if (w_eor) begin
      w_sh_load = 1'b1;
      if (!w_last_rep) begin
        w_rep_left_next = r_rep_left - CNT_W'(1);
        if (r_gap != '0) begin
          w_state_next   = GAP;
          w_gap_cnt_next = r_gap - GAP_W'(1);
        end else begin
          w_state_next  = SHIFT;
          w_sh_data     = r_pat;
          w_ser_en_next = 1'b1;
        end
      end else begin
        w_state_next = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state    <= IDLE;
      r_rep_left <= '0;
      r_gap      <= '0;
      r_gap_cnt  <= '0;
      r_pat      <= '0;
      r_ser_en   <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_rep_left <= w_rep_left_next;
      r_gap      <= w_gap_next;
      r_gap_cnt  <= w_gap_cnt_next;
      r_pat      <= w_pat_next;
      r_ser_en   <= w_ser_en_next;
      r_done     <= w_done_next;
      r_busy     <= (w_state_next != IDLE);
    end
  end

`ifdef SEQ_PATTERN_TX_PARITY_EN
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) r_ser_par <= 1'b0;
    else       r_ser_par <= w_ser_par_next;
  end
  assign ser_par = r_ser_par;
`else
  assign ser_par = 1'b0;
`endif

  assign pat_ready = (r_state == IDLE);
  assign ser_out   = w_sh_bit;
  assign ser_en    = r_ser_en;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Testbench for seq_pattern_tx: per-cycle expected line state is queued when
// a request is accepted and compared on each falling edge.
module tb_seq_pattern_tx;
  import seq_pattern_pkg::PAT_1011;

  localparam int PAT_W = 4;
`ifdef SEQ_PATTERN_TX_PARITY_EN
  localparam bit PARITY_ON = 1'b1;
`else
  localparam bit PARITY_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] pat_data = '0;
  logic [3:0] rep_cnt = '0;
  logic [3:0] gap = '0;
  logic       pat_valid = 1'b0;
  logic       pat_ready, ser_out, ser_en, ser_par, busy, done;

  always #5 clk = ~clk;

  seq_pattern_tx #(.PAT_W(4), .CNT_W(4), .GAP_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .pat_data(pat_data), .rep_cnt(rep_cnt),
    .gap(gap), .pat_valid(pat_valid), .pat_ready(pat_ready),
    .ser_out(ser_out), .ser_en(ser_en), .ser_par(ser_par),
    .busy(busy), .done(done)
  );

  typedef struct packed {
    logic en; logic out; logic par; logic done; logic ready; logic busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, want, $time);
    end
  endtask

  // Scoreboard: one expected entry per cycle while entries are queued.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("ser_en",    ser_en,    e.en);
      check("ser_out",   ser_out,   e.out);
      check("ser_par",   ser_par,   e.par);
      check("done",      done,      e.done);
      check("pat_ready", pat_ready, e.ready);
      check("busy",      busy,      e.busy);
    end
  end

  // Loopback 1011 Moore detector on the serial line.
  logic [3:0] det_win = '0;
  int         det_hits = 0;
  always @(posedge clk) det_win <= {det_win[2:0], ser_out};
  always @(negedge clk) if (det_win == 4'b1011) det_hits++;

  task automatic push_req(input logic [3:0] p, input logic [3:0] r, input logic [3:0] g);
    int   reps;
    exp_t e;
    reps = (r == 4'd0) ? 1 : int'(r);
    for (int k = 0; k < reps; k++) begin
      for (int b = PAT_W - 1; b >= 0; b--) begin
        e = '0;
        e.en = 1'b1; e.out = p[b]; e.busy = 1'b1;
        e.done = (k == reps - 1) && (b == 0) && !PARITY_ON;
        exp_q.push_back(e);
      end
      if (PARITY_ON) begin
        e = '0;
        e.en = 1'b1; e.out = ^p; e.par = 1'b1; e.busy = 1'b1;
        e.done = (k == reps - 1);
        exp_q.push_back(e);
      end
      if (k < reps - 1) begin
        for (int j = 0; j < int'(g); j++) begin
          e = '0;
          e.busy = 1'b1;
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic push_idle();
    exp_t e;
    e = '0;
    e.ready = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain();
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 2000) begin
      @(negedge clk); #1;
      i++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic send(input logic [3:0] p, input logic [3:0] r, input logic [3:0] g, input bit poke);
    check("ready_pre", pat_ready, 1);
    pat_data = p; rep_cnt = r; gap = g; pat_valid = 1'b1;
    @(posedge clk); #1;
    pat_valid = 1'b0;
    push_req(p, r, g);
    push_idle();
    $display("req pat=%b rep=%0d gap=%0d poke=%0d", p, r, g, poke);
    if (poke) begin
      @(posedge clk); #1;
      pat_data = 4'hF; pat_valid = 1'b1;
      @(posedge clk); #1;
      pat_valid = 1'b0;
    end
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t dummy;
    int   keep;

    // Reset state, during and after reset
    repeat (2) @(negedge clk);
    check("rst_ser_out", ser_out, 0);
    check("rst_ser_en",  ser_en,  0);
    check("rst_ser_par", ser_par, 0);
    check("rst_busy",    busy,    0);
    check("rst_done",    done,    0);
    check("rst_ready",   pat_ready, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("post_rst_ready", pat_ready, 1);
    check("post_rst_en",    ser_en,    0);
    check("post_rst_busy",  busy,      0);

    send(PAT_1011, 4'd1, 4'd0, 1'b0);   // single frame
    send(PAT_1011, 4'd3, 4'd2, 1'b0);   // repeats with gaps
    send(PAT_1011, 4'd0, 4'd0, 1'b0);   // rep 0 -> 1
    send(PAT_1011, 4'd1, 4'd5, 1'b0);   // gap unused with one rep
    send(4'b0110,  4'd15, 4'd1, 1'b0);  // all-ones repeat count
    send(PAT_1011, 4'd2, 4'd1, 1'b1);   // request during busy ignored

    // pat_valid held high across done: second accept in first IDLE cycle
    check("ready_pre_hold", pat_ready, 1);
    pat_data = PAT_1011; rep_cnt = 4'd1; gap = 4'd0; pat_valid = 1'b1;
    @(posedge clk); #1;
    push_req(PAT_1011, 4'd1, 4'd0);
    push_idle();
    push_req(PAT_1011, 4'd1, 4'd0);
    push_idle();
    $display("req pat=1011 rep=1 gap=0 held-valid x2");
    repeat (PAT_W + (PARITY_ON ? 1 : 0) + 1) @(posedge clk);
    #1 pat_valid = 1'b0;
    wait_drain();

    for (int t = 0; t < 4; t++) begin
      send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 1'b0);
    end

    // Reset in the middle of repetition 2, bit 2
    check("ready_pre_rst", pat_ready, 1);
    pat_data = PAT_1011; rep_cnt = 4'd3; gap = 4'd0; pat_valid = 1'b1;
    @(posedge clk); #1;
    pat_valid = 1'b0;
    push_req(PAT_1011, 4'd3, 4'd0);
    keep = PAT_W + (PARITY_ON ? 1 : 0) + 3;
    while (exp_q.size() > keep) dummy = exp_q.pop_back();
    $display("req pat=1011 rep=3 gap=0 aborted by reset");
    wait_drain();
    #1 rst_n = 1'b1;
    #1;
    check("abort_ser_out", ser_out, 0);
    check("abort_ser_en",  ser_en,  0);
    check("abort_ser_par", ser_par, 0);
    check("abort_busy",    busy,    0);
    check("abort_done",    done,    0);
    check("abort_ready",   pat_ready, 1);
    repeat (3) begin
      @(negedge clk);
      check("abort_hold_done", done,   0);
      check("abort_hold_en",   ser_en, 0);
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("after_abort_done", done, 0);
    send(PAT_1011, 4'd2, 4'd1, 1'b0);

    // Loopback into the 1011 detector
    repeat (5) @(negedge clk);
    #1 det_hits = 0;
    send(PAT_1011, 4'd2, 4'd0, 1'b0);
    repeat (4) @(negedge clk);
    check("loopback_hits", det_hits, 2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
